// File: rtl/matrix_buffer_reader.sv
// Read-side sequencer for the matrix double buffer: sweeps every read address once per buffer swap and
// streams one byte per lane through a credit-controlled FIFO that absorbs the fixed buffer read latency.
module matrix_buffer_reader #(
    parameter int BYTES_PER_BLOCK    = 2250,
    parameter int BANK_COUNT         = 6,
    parameter int BLOCK_COUNT        = 2,
    parameter int BLOCK_DATA_WIDTH_B = 8,
    parameter int ADDRESS_NUMBER_B   = (BYTES_PER_BLOCK * 8) / BLOCK_DATA_WIDTH_B,
    parameter int READ_LATENCY       = 2,
    parameter int FIFO_DEPTH         = READ_LATENCY + 2,
    localparam int LANES             = BANK_COUNT * BLOCK_COUNT,
    localparam int DATA_W            = LANES * BLOCK_DATA_WIDTH_B,
    localparam int ADDR_W            = $clog2(ADDRESS_NUMBER_B)
) (
    input  logic              I_clkb,
    input  logic              I_rst_n,
    input  logic              I_buffer_updated,
    input  logic              I_data_valid,
    output logic              O_read_enable,
    output logic [ADDR_W-1:0] O_read_address,
    input  logic [DATA_W-1:0] I_data_flat,
    output logic [DATA_W-1:0] O_data_flat,
    output logic              O_valid,
    input  logic              I_ready,
    output logic              O_sof,
    output logic              O_eof,
    output logic              O_busy,
    output logic              O_overrun
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDRESS_NUMBER_B - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                read_en_reg;
    logic                pending_reg;
    logic                overrun_reg;
    // Reads issued but not yet popped downstream (in flight + held in FIFO).
    logic [CNT_W-1:0]    credit_reg;
    logic [CNT_W-1:0]    credit_next;
    logic [CNT_W-1:0]    fifo_count_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [READ_LATENCY-1:0] pipe_vld_reg;
    logic [READ_LATENCY-1:0] pipe_sof_reg;
    logic [READ_LATENCY-1:0] pipe_eof_reg;
    logic [DATA_W+1:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_W+1:0]   head;
    logic                push;
    logic                pop;
    logic                start_sweep;
    logic                credit_ok_next;

    assign push        = pipe_vld_reg[READ_LATENCY-1];
    assign pop         = O_valid & I_ready;
    assign start_sweep = (state_reg == IDLE) & pending_reg & I_data_valid;

    always_comb begin
        credit_next = credit_reg;
        if (read_en_reg)
            credit_next = credit_next + CNT_W'(1);
        if (pop)
            credit_next = credit_next - CNT_W'(1);
    end

    assign credit_ok_next = (credit_next < DEPTH_C);

    // Sweep control; the read strobe is registered, so it is decided from next-cycle credit.
    always_ff @(posedge I_clkb or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            read_en_reg <= 1'b0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            credit_reg  <= '0;
        end else begin
            credit_reg <= credit_next;
            if (I_buffer_updated) begin
                if (pending_reg && !start_sweep)
                    overrun_reg <= 1'b1;
                pending_reg <= 1'b1;
            end else if (start_sweep) begin
                pending_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (start_sweep) begin
                        state_reg   <= SWEEP;
                        addr_reg    <= '0;
                        read_en_reg <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (read_en_reg && addr_reg == LAST_ADDR) begin
                        state_reg   <= DRAIN;
                        read_en_reg <= 1'b0;
                    end else begin
                        if (read_en_reg)
                            addr_reg <= addr_reg + ADDR_W'(1);
                        read_en_reg <= credit_ok_next;
                    end
                end
                DRAIN: begin
                    if (credit_reg == '0)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag pipeline aligned with the buffer read latency.
    always_ff @(posedge I_clkb or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pipe_vld_reg <= '0;
            pipe_sof_reg <= '0;
            pipe_eof_reg <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_sof_reg[i] <= pipe_sof_reg[i-1];
                pipe_eof_reg[i] <= pipe_eof_reg[i-1];
            end
            pipe_vld_reg[0] <= read_en_reg;
            pipe_sof_reg[0] <= read_en_reg & (addr_reg == '0);
            pipe_eof_reg[0] <= read_en_reg & (addr_reg == LAST_ADDR);
        end
    end

    always_ff @(posedge I_clkb) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {pipe_sof_reg[READ_LATENCY-1], pipe_eof_reg[READ_LATENCY-1], I_data_flat};
    end

    always_ff @(posedge I_clkb or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                fifo_count_reg <= fifo_count_reg + CNT_W'(1);
            else if (pop && !push)
                fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        end
    end

    // Outputs are gated by O_valid so stale FIFO contents never appear after reset.
    assign head           = fifo_mem[rd_ptr_reg];
    assign O_valid        = (fifo_count_reg != '0);
    assign O_data_flat    = O_valid ? head[DATA_W-1:0] : '0;
    assign O_sof          = O_valid & head[DATA_W+1];
    assign O_eof          = O_valid & head[DATA_W];
    assign O_read_enable  = read_en_reg;
    assign O_read_address = addr_reg;
    assign O_busy         = (state_reg != IDLE);
    assign O_overrun      = overrun_reg;

endmodule

// File: tb/tb_matrix_buffer_reader.sv
// Bench for matrix_buffer_reader: 8 addresses x 2 lanes, latency-2 buffer model, beat scoreboard
// built from the frame contents, plus per-cycle credit and stall-stability monitoring.
module tb_matrix_buffer_reader;

    localparam int NADDR = 8;
    localparam int DW    = 16;

    logic          I_clkb = 1'b0;
    logic          I_rst_n;
    logic          I_buffer_updated;
    logic          I_data_valid;
    logic          O_read_enable;
    logic [2:0]    O_read_address;
    logic [DW-1:0] I_data_flat;
    logic [DW-1:0] O_data_flat;
    logic          O_valid;
    logic          I_ready;
    logic          O_sof;
    logic          O_eof;
    logic          O_busy;
    logic          O_overrun;

    always #5 I_clkb = ~I_clkb;

    matrix_buffer_reader #(
        .BYTES_PER_BLOCK(8), .BANK_COUNT(2), .BLOCK_COUNT(1),
        .BLOCK_DATA_WIDTH_B(8), .READ_LATENCY(2)
    ) dut (
        .I_clkb(I_clkb), .I_rst_n(I_rst_n), .I_buffer_updated(I_buffer_updated),
        .I_data_valid(I_data_valid), .O_read_enable(O_read_enable), .O_read_address(O_read_address),
        .I_data_flat(I_data_flat), .O_data_flat(O_data_flat), .O_valid(O_valid), .I_ready(I_ready),
        .O_sof(O_sof), .O_eof(O_eof), .O_busy(O_busy), .O_overrun(O_overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Buffer model: data for an address appears two cycles after its read strobe.
    logic [DW-1:0] buf_mem [NADDR];
    logic [DW-1:0] rd_s1, rd_s2;
    always @(posedge I_clkb) begin
        rd_s1 <= O_read_enable ? buf_mem[O_read_address] : 16'hDEAD;
        rd_s2 <= rd_s1;
    end
    assign I_data_flat = rd_s2;

    int ready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random
    initial begin
        I_ready = 1'b1;
        forever begin
            @(posedge I_clkb);
            #1;
            case (ready_mode)
                0:       I_ready = 1'b0;
                1:       I_ready = 1'b1;
                2:       I_ready = ~I_ready;
                default: I_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic [17:0] got [$];
    logic [17:0] exp_q [$];
    int          rd_cnt = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          last_acc = -1;
    logic        stall_prev = 1'b0;
    logic [18:0] prev_word;

    always @(negedge I_clkb) begin
        cyc++;
        if (!I_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (O_read_enable) begin
                chk("rd_addr", {29'd0, O_read_address}, 32'(rd_cnt % NADDR));
                rd_cnt++;
                chk("credit_le_depth", 32'((rd_cnt - acc_cnt) <= 4), 32'd1);
            end
            if (stall_prev)
                chk("stall_hold", {13'd0, O_valid, O_sof, O_eof, O_data_flat}, {13'd0, prev_word});
            if (O_valid && I_ready) begin
                got.push_back({O_sof, O_eof, O_data_flat});
                acc_cnt++;
                if (first_acc < 0)
                    first_acc = cyc;
                last_acc = cyc;
            end
            stall_prev = O_valid && !I_ready;
            prev_word  = {O_valid, O_sof, O_eof, O_data_flat};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge I_clkb);
            #1;
        end
    endtask

    task automatic fill_frame(input bit pattern);
        for (int a = 0; a < NADDR; a++)
            for (int l = 0; l < 2; l++)
                buf_mem[a][l*8 +: 8] = pattern ? {4'(l), 4'(a)} : 8'($urandom_range(0, 255));
    endtask

    task automatic build_exp();
        for (int a = 0; a < NADDR; a++)
            exp_q.push_back({1'(a == 0), 1'(a == NADDR - 1), buf_mem[a]});
    endtask

    task automatic clear_stats();
        got.delete();
        exp_q.delete();
        rd_cnt = 0;
        acc_cnt = 0;
        first_acc = -1;
        last_acc = -1;
    endtask

    task automatic pulse();
        I_buffer_updated = 1'b1;
        tick(1);
        I_buffer_updated = 1'b0;
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while ((got.size() < n || O_busy) && k < 400) begin
            tick(1);
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 400), 32'd1);
    endtask

    task automatic compare_beats(input string tag, input int n);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < n && i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), {14'd0, got[i]}, {14'd0, exp_q[i]});
    endtask

    initial begin
        int k;
        I_rst_n = 1'b0;
        I_buffer_updated = 1'b0;
        I_data_valid = 1'b0;
        fill_frame(1'b1);
        tick(3);
        chk("reset_outs", {O_read_enable, O_read_address, O_valid, O_sof, O_eof, O_busy, O_overrun, O_data_flat}, 32'd0);
        I_rst_n = 1'b1;
        tick(2);

        // 1: full throughput, lane pattern {lane, addr}
        clear_stats();
        ready_mode = 1;
        I_data_valid = 1'b1;
        build_exp();
        pulse();
        chk("t1_busy_pending", {31'd0, O_busy}, 32'd0);
        tick(1);
        chk("t1_sweep_entry", {28'd0, O_busy, O_read_enable, O_valid, 1'b0}, {28'd0, 4'b1100});
        tick(2);
        chk("t1_valid_early", {31'd0, O_valid}, 32'd0);
        tick(1);
        chk("t1_first_beat", {13'd0, O_valid, O_sof, O_eof, O_data_flat}, {13'd0, 1'b1, exp_q[0]});
        wait_done(8, "t1");
        compare_beats("t1", 8);
        chk("t1_consecutive", 32'(last_acc - first_acc), 32'd7);
        chk("t1_reads", rd_cnt, 32'd8);
        chk("t1_overrun", {31'd0, O_overrun}, 32'd0);

        // 2: ready toggling
        clear_stats();
        fill_frame(1'b0);
        build_exp();
        ready_mode = 2;
        pulse();
        wait_done(8, "t2");
        compare_beats("t2", 8);

        // 3: ready held low -> credit stalls reads at FIFO depth
        clear_stats();
        fill_frame(1'b0);
        build_exp();
        ready_mode = 0;
        pulse();
        tick(20);
        chk("t3_reads_stalled", rd_cnt, 32'd4);
        chk("t3_valid_held", {31'd0, O_valid}, 32'd1);
        ready_mode = 1;
        wait_done(8, "t3");
        compare_beats("t3", 8);
        chk("t3_reads", rd_cnt, 32'd8);

        // 4: second pulse mid-sweep, third while pending -> overrun
        clear_stats();
        fill_frame(1'b0);
        build_exp();
        build_exp();
        ready_mode = 1;
        pulse();
        k = 0;
        while (got.size() < 3 && k < 100) begin
            tick(1);
            k++;
        end
        chk("t4_beat3_timeout", 32'(k < 100), 32'd1);
        pulse();
        chk("t4_no_overrun_yet", {31'd0, O_overrun}, 32'd0);
        pulse();
        chk("t4_overrun", {31'd0, O_overrun}, 32'd1);
        wait_done(16, "t4");
        compare_beats("t4", 16);
        chk("t4_reads", rd_cnt, 32'd16);

        // 5: sweep waits for I_data_valid
        clear_stats();
        fill_frame(1'b0);
        build_exp();
        I_data_valid = 1'b0;
        pulse();
        tick(10);
        chk("t5_no_reads", rd_cnt, 32'd0);
        chk("t5_not_busy", {31'd0, O_busy}, 32'd0);
        I_data_valid = 1'b1;
        tick(1);
        chk("t5_start", {30'd0, O_busy, O_read_enable}, 32'd3);
        wait_done(8, "t5");
        compare_beats("t5", 8);

        // 6: asynchronous reset at beat 5
        clear_stats();
        fill_frame(1'b0);
        build_exp();
        pulse();
        k = 0;
        while (got.size() < 5 && k < 100) begin
            tick(1);
            k++;
        end
        chk("t6_beat5_timeout", 32'(k < 100), 32'd1);
        I_rst_n = 1'b0;
        #1;
        chk("t6_reset_outs", {O_read_enable, O_read_address, O_valid, O_sof, O_eof, O_busy, O_overrun, O_data_flat}, 32'd0);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("t6_beat%0d", i), {14'd0, got[i]}, {14'd0, exp_q[i]});
        clear_stats();
        tick(3);
        I_rst_n = 1'b1;
        tick(10);
        chk("t6_quiet", {rd_cnt[28:0], O_valid, O_busy, O_overrun}, 32'd0);

        // 7: random backpressure on a random frame
        clear_stats();
        fill_frame(1'b0);
        build_exp();
        ready_mode = 3;
        pulse();
        wait_done(8, "t7");
        compare_beats("t7", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
